// File: rtl/irs_readout_ctrl.sv
// Readout sequencer for a DDA sample array: walks every enabled channel/sample and streams the results over valid/ready.
// Optional per-channel enable mask is built in when IRS_READOUT_CHMASK_EN is defined.
module irs_readout_ctrl #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        irs_smpall_o,
  output logic [5:0]  irs_smp_o,
  output logic [2:0]  irs_ch_o,
  output logic        irs_doe_o,
  output logic        irs_rd_addr_rst_o,
  output logic        irs_rd_addr_adv_o,
  input  logic [11:0] irs_dat_i,
  output logic [15:0] dat_o,
  output logic        valid_o,
  input  logic        ready_i,
`ifdef IRS_READOUT_CHMASK_EN
  input  logic [7:0]  ch_mask_i,
`endif
  output logic [2:0]  dbg_state_o
);

  // Handshake: a word moves on any rising edge where valid_o && ready_i. Once
  // valid_o is raised, dat_o stays frozen and valid_o stays high until that edge.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARST   = 3'd1,
    SETTLE = 3'd2,
    LATCH  = 3'd3,
    XFER   = 3'd4,
    NEXT   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     state;
  logic [5:0] smp;
  logic [2:0] ch;
  logic [3:0] settle_cnt;
  logic [7:0] mask_q;
  logic [7:0] start_mask;
  logic       last_w;

`ifdef IRS_READOUT_CHMASK_EN
  assign start_mask = ch_mask_i;
`else
  assign start_mask = 8'hFF;
`endif

  function automatic logic [2:0] lowest_en(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [2:0] highest_en(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next enabled channel above c; last-word detection guarantees one exists.
  function automatic logic [2:0] next_en(input logic [7:0] m, input logic [2:0] c);
    logic [2:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) r = 3'(i);
    end
    return r;
  endfunction

  assign last_w      = (smp == 6'd63) && (ch == highest_en(mask_q));
  assign irs_smp_o   = smp;
  assign irs_ch_o    = ch;
  assign dbg_state_o = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state             <= IDLE;
      smp               <= 6'd0;
      ch                <= 3'd0;
      settle_cnt        <= 4'd0;
      mask_q            <= 8'h00;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      irs_smpall_o      <= 1'b0;
      irs_doe_o         <= 1'b0;
      irs_rd_addr_rst_o <= 1'b0;
      irs_rd_addr_adv_o <= 1'b0;
      dat_o             <= 16'h0000;
      valid_o           <= 1'b0;
    end else begin
      irs_rd_addr_rst_o <= 1'b0;
      irs_rd_addr_adv_o <= 1'b0;
      done_o            <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            mask_q <= start_mask;
            if (start_mask == 8'h00) begin
              // Nothing to read: skip straight to the end-of-block pulse.
              state             <= DONE;
              done_o            <= 1'b1;
              irs_rd_addr_adv_o <= 1'b1;
            end else begin
              state             <= ARST;
              irs_rd_addr_rst_o <= 1'b1;
              irs_doe_o         <= 1'b1;
              irs_smpall_o      <= 1'b1;
              ch                <= lowest_en(start_mask);
              smp               <= 6'd0;
            end
          end
        end
        ARST: begin
          state      <= SETTLE;
          settle_cnt <= 4'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= LATCH;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        LATCH: begin
          dat_o   <= {last_w, ch, irs_dat_i};
          valid_o <= 1'b1;
          state   <= XFER;
        end
        XFER: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            if (dat_o[15]) begin
              state             <= DONE;
              done_o            <= 1'b1;
              irs_rd_addr_adv_o <= 1'b1;
              irs_doe_o         <= 1'b0;
              irs_smpall_o      <= 1'b0;
            end else begin
              state <= NEXT;
              if (smp == 6'd63) begin
                smp <= 6'd0;
                ch  <= next_en(mask_q, ch);
              end else begin
                smp <= smp + 6'd1;
              end
            end
          end
        end
        NEXT: begin
          state      <= SETTLE;
          settle_cnt <= 4'(SETTLE_CYCLES - 1);
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irs_readout_ctrl.sv
// Directed/randomized bench for irs_readout_ctrl: a simple DDA sample memory feeds irs_dat_i and
// a queue of expected words is built from the channel/sample ordering rules.
module tb_irs_readout_ctrl;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic        busy, done, smpall, doe, arst, adv, valid;
  logic [5:0]  smp;
  logic [2:0]  ch;
  logic [2:0]  dbg_state;
  logic [11:0] dat_in;
  logic [15:0] dat;
`ifdef IRS_READOUT_CHMASK_EN
  logic [7:0]  ch_mask = 8'hFF;
`endif

  logic [11:0] mem [512];
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int words, dones, advs, rsts, period, done_cyc, aborted;
  logic [15:0] last_word;

  // Clock and reset
  always #5 clk = ~clk;

  // Behaves like the DDA: DAT shows the stored sample at the addressed channel/sample.
  assign dat_in = mem[{ch, smp}];

  irs_readout_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .start_i          (start),
    .busy_o           (busy),
    .done_o           (done),
    .irs_smpall_o     (smpall),
    .irs_smp_o        (smp),
    .irs_ch_o         (ch),
    .irs_doe_o        (doe),
    .irs_rd_addr_rst_o(arst),
    .irs_rd_addr_adv_o(adv),
    .irs_dat_i        (dat_in),
    .dat_o            (dat),
    .valid_o          (valid),
    .ready_i          (ready),
`ifdef IRS_READOUT_CHMASK_EN
    .ch_mask_i        (ch_mask),
`endif
    .dbg_state_o      (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stream: each enabled channel in ascending order, samples 0..63,
  // last flag only on sample 63 of the highest enabled channel.
  task automatic build_exp(input logic [7:0] m, input bit const_abc);
    int hi;
    exp_q.delete();
    for (int i = 0; i < 512; i++) mem[i] = const_abc ? 12'hABC : 12'($urandom);
    hi = -1;
    for (int c = 0; c < 8; c++) if (m[c]) hi = c;
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        for (int s = 0; s < 64; s++) begin
          exp_q.push_back({(c == hi) && (s == 63), 3'(c), mem[c * 64 + s]});
        end
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {busy, done, smpall, smp, ch, doe, arst, adv, dat, valid, dbg_state}, 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 10 cycles while word 3 is offered.
  task automatic run_block(input int mode, input int abort_at, input int restart_at);
    int cyc, stall, t1;
    bit just, fin, restarted;
    logic [15:0] w;
    cyc = 0; stall = 0; t1 = 0; just = 0; fin = 0; restarted = 0;
    words = 0; dones = 0; advs = 0; rsts = 0; period = 0; done_cyc = -1; aborted = 0;
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (just && exp_q.size() > 0) begin
        w = exp_q[0];
        check("next_smp", smp, words % 64);
        check("next_ch", ch, w[14:12]);
      end
      just = 0;
      if (arst) rsts++;
      if (adv) advs++;
      check("doe", doe, busy && !done);
      check("smpall", smpall, busy && !done);
      if (done) begin
        dones++;
        done_cyc = cyc;
        check("done_empty_q", exp_q.size(), 0);
        fin = 1;
      end
      if (abort_at >= 0 && words == abort_at && valid) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_outputs");
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("abort_no_done", done, 1'b0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("abort_idle", busy, 1'b0);
        end
        aborted = 1;
        return;
      end
      case (mode)
        0: ready = 1'b1;
        1: ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (words == 3 && stall < 10) begin
            ready = 1'b0;
            stall++;
          end else begin
            ready = 1'b1;
          end
        end
      endcase
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1'b1, 1'b0);
        end else begin
          w = exp_q[0];
          check("word", dat, w);
          check("smp_hold", smp, words % 64);
          check("ch_hold", ch, w[14:12]);
          if (ready) begin
            last_word = exp_q.pop_front();
            words++;
            just = 1;
            if (words == 1) t1 = cyc;
            if (words == 2) period = cyc - t1;
          end
        end
      end
      if (restart_at >= 0 && words == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
    end
    if (!fin) check("block_timeout", cyc, 0);
  endtask

  initial begin
    int edges;
    // Reset state
    rst_n = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 12'h000;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("no_start_on_release", busy, 1'b0);

    // Timing and full block with constant data
    build_exp(8'hFF, 1'b1);
    ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("arst_pulse", arst, 1'b1);
    check("busy_on_accept", busy, 1'b1);
    edges = 0;
    while (!valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) check("arst_one_cycle", arst, 1'b0);
    end
    check("first_valid_edge", edges, S + 2);
    check("first_word", dat, 16'h0ABC);
    run_block(0, -1, -1);
    check("full_words", words, 512);
    check("full_dones", dones, 1);
    check("full_adv", advs, 1);
    check("full_period", period, S + 3);
    check("full_last_word", last_word, 16'hFABC);

    // Stall during word 3
    build_exp(8'hFF, 1'b0);
    do_start();
    run_block(2, -1, -1);
    check("stall_words", words, 512);
    check("stall_dones", dones, 1);
    check("stall_arst", rsts, 1);

    // Random back-pressure
    build_exp(8'hFF, 1'b0);
    do_start();
    run_block(1, -1, -1);
    check("rand_words", words, 512);
    check("rand_dones", dones, 1);
    check("rand_adv", advs, 1);

    // Second start mid-block is ignored
    build_exp(8'hFF, 1'b0);
    do_start();
    run_block(0, -1, 200);
    check("restart_words", words, 512);
    check("restart_dones", dones, 1);
    check("restart_arst", rsts, 1);

    // Reset during word 100, then a fresh block
    build_exp(8'hFF, 1'b0);
    do_start();
    run_block(0, 100, -1);
    check("abort_taken", aborted, 1);
    check("abort_dones", dones, 0);
    build_exp(8'hFF, 1'b0);
    do_start();
    run_block(1, -1, -1);
    check("post_abort_words", words, 512);
    check("post_abort_dones", dones, 1);

`ifdef IRS_READOUT_CHMASK_EN
    // Sparse mask: ch2 then ch7
    ch_mask = 8'b1000_0100;
    build_exp(ch_mask, 1'b0);
    do_start();
    run_block(1, -1, -1);
    check("mask_words", words, 128);
    check("mask_dones", dones, 1);
    check("mask_last", last_word[15:12], 4'hF);
    // Empty mask
    ch_mask = 8'h00;
    build_exp(ch_mask, 1'b0);
    do_start();
    run_block(0, -1, -1);
    check("mask0_words", words, 0);
    check("mask0_done_cyc", done_cyc, 1);
    check("mask0_arst", rsts, 0);
    check("mask0_adv", advs, 1);
    ch_mask = 8'hFF;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irs_readout_ctrl.md
IRS_READOUT_CTRL -- requirements
Module: irs_readout_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 3, giving the number of cycles from SMP/CH change to DAT capture; legal range is 1..15.
REQ-002 SHALL have ports `clk_i` (input, 1, sole clock) and `rst_n_i` (input, 1, asynchronous active-low reset); all logic is on `clk_i` rising edge.
REQ-003 SHALL have `start_i` (input, 1): single-cycle request to read one full block.
REQ-004 SHALL have `busy_o` (output, 1), high from the start acceptance through the DONE state; and `done_o` (output, 1), a one-cycle pulse at block end.
REQ-005 SHALL have `irs_smpall_o` (output, 1), `irs_smp_o` (output, 6) and `irs_ch_o` (output, 3), driving DDA SMPALL/SMP/CH.
REQ-006 SHALL have `irs_doe_o`, `irs_rd_addr_rst_o` and `irs_rd_addr_adv_o` (outputs, 1 each), driving DDA RD[2], RD[1] and RD[0].
REQ-007 SHALL have `irs_dat_i` (input, 12), the DDA DAT bus.
REQ-008 SHALL have `dat_o` (output, 16) = {last, ch[2:0], sample[11:0]}, plus `valid_o` (output, 1) and `ready_i` (input, 1).
REQ-009 SHALL have `ch_mask_i` (input, 8) only when IRS_READOUT_CHMASK_EN is defined.

Function
REQ-010 SHALL implement the states IDLE, ARST, SETTLE, LATCH, XFER, NEXT and DONE.
REQ-011 IDLE: on `start_i`=1 go to ARST; `start_i` SHALL be ignored in every other state.
REQ-012 ARST: `irs_rd_addr_rst_o`=1 for exactly one cycle; load ch to the first enabled channel and smp to 0; go to SETTLE.
REQ-013 From ARST through NEXT, `irs_doe_o`=1 and `irs_smpall_o`=1; both SHALL be 0 in IDLE and DONE.
REQ-014 SETTLE SHALL hold for exactly SETTLE_CYCLES cycles, then go to LATCH.
REQ-015 LATCH SHALL register `irs_dat_i` into `dat_o[11:0]`, set ch and last in `dat_o`, and go to XFER.
REQ-016 XFER SHALL hold `valid_o`=1 with `dat_o` stable until `ready_i`=1, with no timeout; on transfer go to NEXT, or to DONE if last=1.
REQ-017 NEXT (one cycle): smp+1; on wrap 63->0, ch advances to the next enabled channel; go to SETTLE.
REQ-018 last SHALL be 1 only for smp=63 of the final enabled channel.
REQ-019 DONE (one cycle): `done_o`=1 and `irs_rd_addr_adv_o`=1; go to IDLE.
REQ-020 `irs_smp_o` and `irs_ch_o` SHALL reflect the registered smp and ch, changing only in ARST and NEXT.
REQ-021 Timing: `valid_o` SHALL rise SETTLE_CYCLES+2 edges after the edge sampling `start_i`; with `ready_i` held high, the word period is SETTLE_CYCLES+3 cycles.
REQ-022 `valid_o` SHALL be 0 outside XFER.

Reset
REQ-023 While `rst_n_i`=0: state=IDLE and all outputs 0, including `dat_o`=16'h0000, smp=0 and ch=0.
REQ-024 Reset assertion mid-block SHALL abort immediately with no `done_o`; the first `start_i` after release begins a fresh block.
REQ-025 The reset deassertion edge SHALL NOT produce a `start_i` acceptance unless `start_i`=1 on a later edge.

Configuration
REQ-026 With IRS_READOUT_CHMASK_EN defined:
- `ch_mask_i` is sampled in IDLE when `start_i` is accepted.
- Channels with mask bit 0 are skipped.
- last applies to the highest enabled channel.
- Mask=8'h00: go IDLE->DONE directly, with no ARST, no words and `done_o` still pulsed.
REQ-027 Without IRS_READOUT_CHMASK_EN: no `ch_mask_i` port, and all 8 channels are read (512 words).

Verification
REQ-028 SETTLE_CYCLES=3, `ready_i`=1, `irs_dat_i`=12'hABC, `start_i` at edge 0 -> `irs_rd_addr_rst_o` pulse after edge 0; first `valid_o` after edge 5 with `dat_o`=16'h0ABC; 512 words; final word 16'hFABC; one `done_o`/`irs_rd_addr_adv_o` pulse.
REQ-029 `ready_i` low for 10 cycles during word 3 -> `dat_o` and `irs_smp_o`=3 held, `valid_o` stays 1; no word lost or duplicated.
REQ-030 Smp wrap: after ch0 smp63 transfers -> `irs_ch_o`=1, `irs_smp_o`=0 at NEXT; next `dat_o[14:12]`=3'd1.
REQ-031 `rst_n_i` low during word 100 -> all outputs 0 asynchronously; no `done_o`; a new `start_i` yields a full 512-word block.
REQ-032 Second `start_i` mid-block -> ignored; exactly 512 words.
REQ-033 CHMASK_EN, mask 8'b1000_0100 -> 128 words (ch2 then ch7), last only on ch7 smp63; mask 8'h00 -> `done_o` one cycle after start, zero words.
